vga_pattern_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 timing-plus-image pair. Merges both functions into one block: an internal pixel-enable divider, a VGA timing generator and a selectable test-pattern source.
- Timing, colour depth, sync polarity and pattern geometry are parameters. Pattern mode is switchable at runtime, glitch-free, on frame boundaries.
- Sits directly behind the board VGA pins. Also exports counters and frame strobe for overlay/UART-driven blocks.

---
 rtl/vga_pattern_gen.sv | 177 +++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_pattern_gen
// Description : Parametrised VGA timing generator with pixel-enable divider
//               and runtime-selectable test patterns (solid/bars/check/box).
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pattern_gen #(
    parameter int   CLK_DIV    = 4,
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic HSYNC_POL  = 1'b0,
    parameter logic VSYNC_POL  = 1'b0,
    parameter int   COLOR_BITS = 4,
    parameter int   CHECK_LOG2 = 5,
    parameter int   BOX_SIZE   = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [1:0]                mode,
    input  logic [3*COLOR_BITS-1:0]   solid_rgb,
    output logic [COLOR_BITS-1:0]     vgaRed,
    output logic [COLOR_BITS-1:0]     vgaGreen,
    output logic [COLOR_BITS-1:0]     vgaBlue,
    output logic                      Hsync,
    output logic                      Vsync,
    output logic [9:0]                h_count,
    output logic [9:0]                v_count,
    output logic                      active,
    output logic                      frame_start
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST   = c_DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]         c_H_LAST     = 10'(c_H_TOTAL - 1);
    localparam logic [9:0]         c_V_LAST     = 10'(c_V_TOTAL - 1);
    localparam logic [9:0]         c_H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0]         c_V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]         c_HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]         c_HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]         c_VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]         c_VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]         c_BAR_W      = 10'(H_ACTIVE / 8);
    localparam logic [9:0]         c_BOX_X_LAST = 10'(H_ACTIVE - BOX_SIZE);
    localparam logic [9:0]         c_BOX_Y0     = 10'((V_ACTIVE - BOX_SIZE) / 2);
    localparam logic [9:0]         c_BOX_Y1     = 10'((V_ACTIVE - BOX_SIZE) / 2 + BOX_SIZE);
    localparam logic [10:0]        c_BOX_SIZE   = 11'(BOX_SIZE);

    if (c_H_TOTAL > 1024) begin : g_h_total_check
        $error("vga_pattern_gen: H_TOTAL exceeds 1024");
    end
    if (c_V_TOTAL > 1024) begin : g_v_total_check
        $error("vga_pattern_gen: V_TOTAL exceeds 1024");
    end
    if (CLK_DIV < 1) begin : g_clk_div_check
        $error("vga_pattern_gen: CLK_DIV must be at least 1");
    end

    logic [c_DIV_W-1:0]      r_div;
    logic [9:0]              r_h;
    logic [9:0]              r_v;
    logic [9:0]              r_box_x;
    logic [1:0]              r_mode;
    logic [3*COLOR_BITS-1:0] r_rgb;
    logic                    r_hsync;
    logic                    r_vsync;
    logic                    r_active;
    logic                    r_frame_start;

    logic                    w_pix_en;
    logic                    w_h_last;
    logic                    w_v_last;
    logic                    w_vis;
    logic                    w_hs_on;
    logic                    w_vs_on;
    logic                    w_in_box;
    logic                    w_check;
    logic [9:0]              w_bar_q;
    logic [2:0]              w_bar_idx;
    logic [2:0]              w_code;
    logic [3*COLOR_BITS-1:0] w_rgb;

    assign w_pix_en = enable && (r_div == c_DIV_LAST);
    assign w_h_last = (r_h == c_H_LAST);
    assign w_v_last = (r_v == c_V_LAST);

    // Pattern decode works on the pre-increment counters; the result is
    // registered on pix_en, giving the one-pixel output lag.
    assign w_vis    = (r_h < c_H_ACT) && (r_v < c_V_ACT);
    assign w_hs_on  = (r_h >= c_HS_START) && (r_h < c_HS_END);
    assign w_vs_on  = (r_v >= c_VS_START) && (r_v < c_VS_END);
    assign w_in_box = (r_h >= r_box_x) && ({1'b0, r_h} < ({1'b0, r_box_x} + c_BOX_SIZE))
                   && (r_v >= c_BOX_Y0) && (r_v < c_BOX_Y1);
    assign w_check   = r_h[CHECK_LOG2] ^ r_v[CHECK_LOG2];
    assign w_bar_q   = r_h / c_BAR_W;
    assign w_bar_idx = (w_bar_q > 10'd7) ? 3'd7 : w_bar_q[2:0];
    assign w_code    = ~w_bar_idx;

    always_comb begin
        w_rgb = '0;
        if (w_vis) begin
            case (r_mode)
                2'd0: w_rgb = solid_rgb;
                2'd1: w_rgb = {{COLOR_BITS{w_code[2]}}, {COLOR_BITS{w_code[1]}},
                               {COLOR_BITS{w_code[0]}}};
                2'd2: w_rgb = {(3*COLOR_BITS){w_check}};
                default: begin
                    if (w_in_box) begin
                        w_rgb = '1;
                    end else begin
                        w_rgb = {{(2*COLOR_BITS){1'b0}}, {COLOR_BITS{1'b1}}};
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div         <= '0;
            r_h           <= '0;
            r_v           <= '0;
            r_box_x       <= '0;
            r_mode        <= '0;
            r_rgb         <= '0;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_active      <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (enable) begin
                r_div <= (r_div == c_DIV_LAST) ? '0 : r_div + c_DIV_W'(1);
            end
            if (w_pix_en) begin
                r_rgb    <= w_rgb;
                r_hsync  <= w_hs_on ? HSYNC_POL : ~HSYNC_POL;
                r_vsync  <= w_vs_on ? VSYNC_POL : ~VSYNC_POL;
                r_active <= w_vis;
                if (w_h_last) begin
                    r_h <= '0;
                    r_v <= w_v_last ? 10'd0 : r_v + 10'd1;
                end else begin
                    r_h <= r_h + 10'd1;
                end
                // Mode and box position only change as a new frame begins.
                if (w_h_last && w_v_last) begin
                    r_frame_start <= 1'b1;
                    r_mode        <= mode;
                    r_box_x       <= (r_box_x == c_BOX_X_LAST) ? 10'd0 : r_box_x + 10'd1;
                end
            end
        end
    end

    assign vgaRed      = r_rgb[3*COLOR_BITS-1:2*COLOR_BITS];
    assign vgaGreen    = r_rgb[2*COLOR_BITS-1:COLOR_BITS];
    assign vgaBlue     = r_rgb[COLOR_BITS-1:0];
    assign Hsync       = r_hsync;
    assign Vsync       = r_vsync;
    assign h_count     = r_h;
    assign v_count     = r_v;
    assign active      = r_active;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_pattern_gen
// Description : Randomised self-checking bench for vga_pattern_gen using a
//               reduced timing so many whole frames fit in a short run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pattern_gen;

    localparam int   CLK_DIV    = 2;
    localparam int   H_ACTIVE   = 16;
    localparam int   H_FP       = 2;
    localparam int   H_SYNC     = 3;
    localparam int   H_BP       = 3;
    localparam int   V_ACTIVE   = 12;
    localparam int   V_FP       = 1;
    localparam int   V_SYNC     = 2;
    localparam int   V_BP       = 2;
    localparam logic HSYNC_POL  = 1'b0;
    localparam logic VSYNC_POL  = 1'b1;
    localparam int   COLOR_BITS = 4;
    localparam int   CHECK_LOG2 = 2;
    localparam int   BOX_SIZE   = 4;

    localparam int c_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_FRAME    = c_H_TOTAL * c_V_TOTAL;
    localparam int c_BOX_SPAN = H_ACTIVE - BOX_SIZE + 1;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [1:0]  mode;
    logic [11:0] solid_rgb;
    logic [3:0]  vgaRed;
    logic [3:0]  vgaGreen;
    logic [3:0]  vgaBlue;
    logic        Hsync;
    logic        Vsync;
    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic        active;
    logic        frame_start;

    vga_pattern_gen #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL), .COLOR_BITS(COLOR_BITS),
        .CHECK_LOG2(CHECK_LOG2), .BOX_SIZE(BOX_SIZE)
    ) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .solid_rgb(solid_rgb),
        .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
        .Hsync(Hsync), .Vsync(Vsync), .h_count(h_count), .v_count(v_count),
        .active(active), .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors = 0;
    int          errors  = 0;
    int          n_en    = 0;   // enabled clocks since reset
    int          mode_at [0:63];
    logic [11:0] e_rgb;
    logic        e_hs;
    logic        e_vs;
    logic        e_act;
    logic        e_fs;
    int          gap     = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (n_en=%0d)", tag, got, exp, n_en);
        end
    endtask

    function automatic logic [11:0] ref_rgb(input int h, input int v, input int m,
                                            input int bx, input logic [11:0] solid);
        int idx;
        int code;
        int by0;
        if (!(h < H_ACTIVE && v < V_ACTIVE)) return 12'h000;
        case (m)
            0: return solid;
            1: begin
                idx = h / (H_ACTIVE / 8);
                if (idx > 7) idx = 7;
                code = 7 - idx;
                return {((code / 4) % 2 == 1) ? 4'hF : 4'h0,
                        ((code / 2) % 2 == 1) ? 4'hF : 4'h0,
                        (code % 2 == 1)       ? 4'hF : 4'h0};
            end
            2: return ((((h >> CHECK_LOG2) ^ (v >> CHECK_LOG2)) & 1) == 1) ? 12'hFFF : 12'h000;
            default: begin
                by0 = (V_ACTIVE - BOX_SIZE) / 2;
                if (h >= bx && h < bx + BOX_SIZE && v >= by0 && v < by0 + BOX_SIZE)
                    return 12'hFFF;
                return 12'h00F;
            end
        endcase
    endfunction

    // One clock: let the DUT see the current inputs, advance the model, check.
    task automatic tick();
        int p, q, fq, qh, qv;
        @(posedge clk);
        if (reset) begin
            n_en       = 0;
            mode_at[0] = 0;
            e_rgb      = 12'h000;
            e_hs       = ~HSYNC_POL;
            e_vs       = ~VSYNC_POL;
            e_act      = 1'b0;
            e_fs       = 1'b0;
        end else begin
            e_fs = 1'b0;
            if (enable) begin
                n_en++;
                if (n_en % CLK_DIV == 0) begin
                    p  = n_en / CLK_DIV;
                    q  = p - 1;
                    fq = q / c_FRAME;
                    qh = q % c_H_TOTAL;
                    qv = (q / c_H_TOTAL) % c_V_TOTAL;
                    e_rgb = ref_rgb(qh, qv, mode_at[fq % 64], fq % c_BOX_SPAN, solid_rgb);
                    e_hs  = (qh >= H_ACTIVE + H_FP && qh < H_ACTIVE + H_FP + H_SYNC) ? HSYNC_POL : ~HSYNC_POL;
                    e_vs  = (qv >= V_ACTIVE + V_FP && qv < V_ACTIVE + V_FP + V_SYNC) ? VSYNC_POL : ~VSYNC_POL;
                    e_act = (qh < H_ACTIVE) && (qv < V_ACTIVE);
                    if (p % c_FRAME == 0) begin
                        e_fs = 1'b1;
                        mode_at[(p / c_FRAME) % 64] = int'(mode);
                    end
                end
            end
        end
        #1;
        chk("h_count", 32'(h_count), 32'((n_en / CLK_DIV) % c_H_TOTAL));
        chk("v_count", 32'(v_count), 32'(((n_en / CLK_DIV) / c_H_TOTAL) % c_V_TOTAL));
        chk("rgb", 32'({vgaRed, vgaGreen, vgaBlue}), 32'(e_rgb));
        chk("hsync", 32'(Hsync), 32'(e_hs));
        chk("vsync", 32'(Vsync), 32'(e_vs));
        chk("active", 32'(active), 32'(e_act));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
    endtask

    task automatic drive_enable();
        if (gap > 0) begin
            enable = 1'b0;
            gap--;
        end else begin
            enable = 1'b1;
            if ($urandom_range(0, 99) == 0) gap = $urandom_range(1, 30);
        end
    endtask

    initial begin
        int budget;
        reset     = 1'b1;
        enable    = 1'b0;
        mode      = 2'd1;
        solid_rgb = 12'h000;
        for (int i = 0; i < 64; i++) mode_at[i] = 0;
        repeat (3) tick();
        reset = 1'b0;

        // Phase 1: a few frames with random mode, colour and enable gaps.
        for (int c = 0; c < 3 * c_FRAME * CLK_DIV; c++) begin
            if ($urandom_range(0, 199) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 49) == 0) solid_rgb = 12'($urandom);
            drive_enable();
            tick();
        end

        // Long freeze somewhere mid-line, then resume.
        enable = 1'b1;
        repeat (37) tick();
        enable = 1'b0;
        repeat (1000) tick();
        enable = 1'b1;
        repeat (300) tick();

        // Mid-frame reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Phase 2: mostly moving box, long enough for box_x to wrap.
        mode   = 2'd3;
        gap    = 0;
        budget = 40000;
        while ((n_en / CLK_DIV) < 16 * c_FRAME + 50 && budget > 0) begin
            if ($urandom_range(0, 1999) == 0) mode = 2'($urandom);
            else if ($urandom_range(0, 499) == 0) mode = 2'd3;
            if ($urandom_range(0, 99) == 0) solid_rgb = 12'($urandom);
            drive_enable();
            tick();
            budget--;
        end
        chk("phase2_budget", 32'(budget > 0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
